hazard_controller: RTL and testbench
====================================

HAZARD_CONTROLLER -- requirements
Module: hazard_controller

Interface
REQ-001 The block SHALL have parameter CNT_W, default 16, giving the width of each event counter.
REQ-002 The block SHALL have parameter FWD_EN, default 1; when 0, forward_a and forward_b are tied to 00.
REQ-003 The block SHALL have port CLK, input, 1 bit: the single pipeline clock; all state changes on its rising edge.
REQ-004 The block SHALL have port RST_N, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have ports ID_rs and ID_rt, input, 5 bits each: source registers of the instruction in IF/ID.
REQ-006 The block SHALL have port ID_uses_rt, input, 1 bit: the IF/ID instruction reads rt (R-type, store, branch).
REQ-007 The block SHALL have ports ID_EX_rs and ID_EX_rt, input, 5 bits each: source registers of the instruction in ID/EX.
REQ-008 The block SHALL have port ID_EX_MemRead, input, 1 bit: the ID/EX instruction is a load.
REQ-009 The block SHALL have ports EX_MEM_RegWrite, input, 1 bit, and EX_MEM_dest, input, 5 bits: EX/MEM writeback enable and destination.
REQ-010 The block SHALL have ports MEM_WB_RegWrite, input, 1 bit, and MEM_WB_dest, input, 5 bits: MEM/WB writeback enable and destination.
REQ-011 The block SHALL have port MEM_IF_pc_src, input, 1 bit: branch taken, resolved in MEM.
REQ-012 The block SHALL have port mem_busy, input, 1 bit: data memory has not completed this cycle.
REQ-013 The block SHALL have ports pc_write and IF_ID_write, output, 1 bit each: PC and IF/ID load enables.
REQ-014 The block SHALL have port ID_EX_bubble, output, 1 bit: zero the ID/EX control bits.
REQ-015 The block SHALL have ports IF_ID_flush, ID_EX_flush and EX_MEM_flush, output, 1 bit each: squash the stage register.
REQ-016 The block SHALL have ports forward_a and forward_b, output, 2 bits each: ALU operand select (00 regfile, 10 EX/MEM, 01 MEM/WB).
REQ-017 The block SHALL have port state, output, 2 bits: current FSM state.
REQ-018 The block SHALL have ports stall_cnt, flush_cnt and freeze_cnt, output, CNT_W bits each: event counters.

Function
REQ-019 The FSM SHALL have states RUN=0, FREEZE=1 and FLUSH=2, encoded on state.
REQ-020 Priority SHALL be: freeze (mem_busy=1) over flush (MEM_IF_pc_src=1) over load-use stall.
REQ-021 Freeze: any state with mem_busy=1 SHALL give pc_write=0, IF_ID_write=0, no flush and no bubble, next state FREEZE, and freeze_cnt+1.
REQ-022 Leaving FREEZE: with mem_busy=0 the FSM SHALL evaluate REQ-023/024 in that same cycle, else go to RUN.
REQ-023 Flush: MEM_IF_pc_src=1 with mem_busy=0 SHALL assert IF_ID_flush, ID_EX_flush and EX_MEM_flush and pc_write=1 in that same cycle, with next state FLUSH and flush_cnt+1.
REQ-024 Load-use: in RUN only, when ID_EX_MemRead=1, ID_EX_rt!=0 and (ID_EX_rt==ID_rs or (ID_uses_rt and ID_EX_rt==ID_rt)), the block SHALL output pc_write=0, IF_ID_write=0, ID_EX_bubble=1 for exactly one cycle, with stall_cnt+1 and state remaining RUN.
REQ-025 In FLUSH, load-use detection SHALL be masked (IF/ID holds a bubble), outputs SHALL be pass-through, and the next state SHALL be RUN.
REQ-026 Pass-through SHALL mean pc_write=1, IF_ID_write=1 and all flush/bubble outputs 0.
REQ-027 Forwarding (combinational, all states): forward_a=10 if EX_MEM_RegWrite and EX_MEM_dest!=0 and EX_MEM_dest==ID_EX_rs.
REQ-028 Otherwise forward_a=01 if MEM_WB_RegWrite and MEM_WB_dest!=0 and MEM_WB_dest==ID_EX_rs; otherwise 00.
REQ-029 forward_b SHALL be computed identically to forward_a using ID_EX_rt.
REQ-030 Counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-031 All control outputs SHALL be combinational from inputs and state, with zero-cycle latency.

Reset
REQ-032 RST_N=0 SHALL immediately set state=RUN and all counters to 0, independent of CLK.
REQ-033 During reset, outputs SHALL be pass-through, with the forwarding outputs still valid.
REQ-034 Reset asserted mid-FREEZE or mid-FLUSH SHALL abandon the state with no residual flush.

Structure
REQ-035 State encodings and forward-select codes SHALL be defined in shared package mips_pkg.
REQ-036 One sub-module, sat_counter (parameter CNT_W, enable, asynchronous active-low reset), SHALL be instantiated three times.

Verification
REQ-037 The bench SHALL drive lw $2 in ID/EX and add using $2 in IF/ID, and check one cycle of pc_write=0, IF_ID_write=0, ID_EX_bubble=1, then pass-through, with stall_cnt=1.
REQ-038 The bench SHALL pulse MEM_IF_pc_src=1 for 1 cycle and check all three flushes=1 that cycle, state=2 the next cycle, RUN after, and flush_cnt=1.
REQ-039 The bench SHALL hold mem_busy=1 for 3 cycles with a load-use present and check the enables low, no bubble, and freeze_cnt=3, then a single bubble on release.
REQ-040 The bench SHALL set EX_MEM_dest=MEM_WB_dest=5, both RegWrite=1, ID_EX_rs=5, and check forward_a=10; with EX_MEM_dest=0, forward_a=01.
REQ-041 The bench SHALL use CNT_W=2 with 5 flushes and check flush_cnt=3 (saturated).
REQ-042 The bench SHALL drop RST_N low mid-FREEZE, between clock edges, and check state=0 and all counters=0 immediately.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared encodings for the pipeline hazard controller.
package mips_pkg;

    localparam int unsigned REG_W = 5;
    localparam int unsigned ST_W  = 2;
    localparam int unsigned FWD_W = 2;

    typedef enum logic [ST_W-1:0] {
        ST_RUN    = 2'd0,
        ST_FREEZE = 2'd1,
        ST_FLUSH  = 2'd2
    } hz_state_t;

    typedef enum logic [FWD_W-1:0] {
        FWD_REGFILE = 2'b00,
        FWD_MEM_WB  = 2'b01,
        FWD_EX_MEM  = 2'b10
    } fwd_sel_t;

    // Operand source select: youngest producer (EX/MEM) wins, $zero never forwards.
    function automatic fwd_sel_t fwd_select(
        input logic [REG_W-1:0] src,
        input logic             ex_mem_we,
        input logic [REG_W-1:0] ex_mem_dest,
        input logic             mem_wb_we,
        input logic [REG_W-1:0] mem_wb_dest
    );
        fwd_sel_t sel;
        sel = FWD_REGFILE;
        if (ex_mem_we && (ex_mem_dest != '0) && (ex_mem_dest == src)) begin
            sel = FWD_EX_MEM;
        end else if (mem_wb_we && (mem_wb_dest != '0) && (mem_wb_dest == src)) begin
            sel = FWD_MEM_WB;
        end
        return sel;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with enable; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Count enabled events until the maximum value is reached.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (en && (count != CNT_MAX)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/hazard_controller.sv
// Pipeline hazard controller: freeze on memory wait, flush on taken branch,
// load-use stall, operand forwarding and event counters.
module hazard_controller
    import mips_pkg::*;
#(
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned FWD_EN = 1
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [REG_W-1:0] ID_rs,
    input  logic [REG_W-1:0] ID_rt,
    input  logic             ID_uses_rt,
    input  logic [REG_W-1:0] ID_EX_rs,
    input  logic [REG_W-1:0] ID_EX_rt,
    input  logic             ID_EX_MemRead,
    input  logic             EX_MEM_RegWrite,
    input  logic [REG_W-1:0] EX_MEM_dest,
    input  logic             MEM_WB_RegWrite,
    input  logic [REG_W-1:0] MEM_WB_dest,
    input  logic             MEM_IF_pc_src,
    input  logic             mem_busy,
    output logic             pc_write,
    output logic             IF_ID_write,
    output logic             ID_EX_bubble,
    output logic             IF_ID_flush,
    output logic             ID_EX_flush,
    output logic             EX_MEM_flush,
    output logic [FWD_W-1:0] forward_a,
    output logic [FWD_W-1:0] forward_b,
    output logic [ST_W-1:0]  state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] freeze_cnt
);

    hz_state_t state_q;
    hz_state_t state_d;
    logic      load_use_c;
    logic      freeze_ev;
    logic      flush_ev;
    logic      stall_ev;

    // Load in ID/EX whose destination is read by the instruction in IF/ID.
    always_comb begin
        load_use_c = ID_EX_MemRead && (ID_EX_rt != '0) &&
                     ((ID_EX_rt == ID_rs) || (ID_uses_rt && (ID_EX_rt == ID_rt)));
    end

    // Next state and pipeline controls; reset forces pass-through.
    always_comb begin
        state_d      = ST_RUN;
        pc_write     = 1'b1;
        IF_ID_write  = 1'b1;
        ID_EX_bubble = 1'b0;
        IF_ID_flush  = 1'b0;
        ID_EX_flush  = 1'b0;
        EX_MEM_flush = 1'b0;
        freeze_ev    = 1'b0;
        flush_ev     = 1'b0;
        stall_ev     = 1'b0;
        if (!RST_N) begin
            state_d = ST_RUN;
        end else if (mem_busy) begin
            pc_write    = 1'b0;
            IF_ID_write = 1'b0;
            state_d     = ST_FREEZE;
            freeze_ev   = 1'b1;
        end else if (MEM_IF_pc_src) begin
            IF_ID_flush  = 1'b1;
            ID_EX_flush  = 1'b1;
            EX_MEM_flush = 1'b1;
            state_d      = ST_FLUSH;
            flush_ev     = 1'b1;
        end else if ((state_q != ST_FLUSH) && load_use_c) begin
            // IF/ID holds a bubble after a flush, so no stall is possible there.
            pc_write     = 1'b0;
            IF_ID_write  = 1'b0;
            ID_EX_bubble = 1'b1;
            stall_ev     = 1'b1;
        end
    end

    // State register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

    // Operand forwarding selects, live in every state including reset.
    generate
        if (FWD_EN != 0) begin : g_fwd
            always_comb begin
                forward_a = fwd_select(ID_EX_rs, EX_MEM_RegWrite, EX_MEM_dest,
                                       MEM_WB_RegWrite, MEM_WB_dest);
                forward_b = fwd_select(ID_EX_rt, EX_MEM_RegWrite, EX_MEM_dest,
                                       MEM_WB_RegWrite, MEM_WB_dest);
            end
        end else begin : g_no_fwd
            assign forward_a = FWD_REGFILE;
            assign forward_b = FWD_REGFILE;
        end
    endgenerate

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (CLK),
        .rst_n (RST_N),
        .en    (stall_ev),
        .count (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (CLK),
        .rst_n (RST_N),
        .en    (flush_ev),
        .count (flush_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_freeze_cnt (
        .clk   (CLK),
        .rst_n (RST_N),
        .en    (freeze_ev),
        .count (freeze_cnt)
    );

endmodule

// File: tb/tb_hazard_controller.sv
// Bench for hazard_controller: directed scenarios plus a randomized run
// against a cycle-level model of the hazard rules.
module tb_hazard_controller;

    logic       CLK;
    logic       RST_N;
    logic [4:0] ID_rs, ID_rt, ID_EX_rs, ID_EX_rt, EX_MEM_dest, MEM_WB_dest;
    logic       ID_uses_rt, ID_EX_MemRead, EX_MEM_RegWrite, MEM_WB_RegWrite;
    logic       MEM_IF_pc_src, mem_busy;

    logic        pc_write, IF_ID_write, ID_EX_bubble, IF_ID_flush, ID_EX_flush, EX_MEM_flush;
    logic [1:0]  forward_a, forward_b, state;
    logic [15:0] stall_cnt, flush_cnt, freeze_cnt;

    logic        s_pc_write, s_IF_ID_write, s_ID_EX_bubble, s_IF_ID_flush, s_ID_EX_flush, s_EX_MEM_flush;
    logic [1:0]  s_forward_a, s_forward_b, s_state;
    logic [1:0]  s_stall_cnt, s_flush_cnt, s_freeze_cnt;

    int n_checks;
    int n_fail;

    hazard_controller dut (
        .CLK(CLK), .RST_N(RST_N),
        .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_uses_rt(ID_uses_rt),
        .ID_EX_rs(ID_EX_rs), .ID_EX_rt(ID_EX_rt), .ID_EX_MemRead(ID_EX_MemRead),
        .EX_MEM_RegWrite(EX_MEM_RegWrite), .EX_MEM_dest(EX_MEM_dest),
        .MEM_WB_RegWrite(MEM_WB_RegWrite), .MEM_WB_dest(MEM_WB_dest),
        .MEM_IF_pc_src(MEM_IF_pc_src), .mem_busy(mem_busy),
        .pc_write(pc_write), .IF_ID_write(IF_ID_write), .ID_EX_bubble(ID_EX_bubble),
        .IF_ID_flush(IF_ID_flush), .ID_EX_flush(ID_EX_flush), .EX_MEM_flush(EX_MEM_flush),
        .forward_a(forward_a), .forward_b(forward_b), .state(state),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .freeze_cnt(freeze_cnt)
    );

    hazard_controller #(.CNT_W(2)) dut_s (
        .CLK(CLK), .RST_N(RST_N),
        .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_uses_rt(ID_uses_rt),
        .ID_EX_rs(ID_EX_rs), .ID_EX_rt(ID_EX_rt), .ID_EX_MemRead(ID_EX_MemRead),
        .EX_MEM_RegWrite(EX_MEM_RegWrite), .EX_MEM_dest(EX_MEM_dest),
        .MEM_WB_RegWrite(MEM_WB_RegWrite), .MEM_WB_dest(MEM_WB_dest),
        .MEM_IF_pc_src(MEM_IF_pc_src), .mem_busy(mem_busy),
        .pc_write(s_pc_write), .IF_ID_write(s_IF_ID_write), .ID_EX_bubble(s_ID_EX_bubble),
        .IF_ID_flush(s_IF_ID_flush), .ID_EX_flush(s_ID_EX_flush), .EX_MEM_flush(s_EX_MEM_flush),
        .forward_a(s_forward_a), .forward_b(s_forward_b), .state(s_state),
        .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt), .freeze_cnt(s_freeze_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs();
        ID_rs = 0; ID_rt = 0; ID_uses_rt = 0; ID_EX_rs = 0; ID_EX_rt = 0;
        ID_EX_MemRead = 0; EX_MEM_RegWrite = 0; EX_MEM_dest = 0;
        MEM_WB_RegWrite = 0; MEM_WB_dest = 0; MEM_IF_pc_src = 0; mem_busy = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        RST_N = 1'b0;
        #1;
        RST_N = 1'b1;
    endtask

    // Reference forwarding rule written straight from the operand-select description.
    function automatic logic [1:0] fwd_model(input logic [4:0] src);
        if (EX_MEM_RegWrite && EX_MEM_dest != 0 && EX_MEM_dest == src) return 2'b10;
        if (MEM_WB_RegWrite && MEM_WB_dest != 0 && MEM_WB_dest == src) return 2'b01;
        return 2'b00;
    endfunction

    task automatic test_reset();
        clear_inputs();
        mem_busy = 1'b1; ID_EX_MemRead = 1'b1; ID_EX_rt = 5'd4; ID_rs = 5'd4;
        RST_N = 1'b0;
        #2;
        n_checks++;
        if (state !== 2'd0 || stall_cnt !== 0 || flush_cnt !== 0 || freeze_cnt !== 0) begin
            n_fail++;
            $display("FAIL reset_state: state=%0d cnts=%0d/%0d/%0d expected 0", state, stall_cnt, flush_cnt, freeze_cnt);
        end
        n_checks++;
        if ({pc_write, IF_ID_write, ID_EX_bubble, IF_ID_flush, ID_EX_flush, EX_MEM_flush} !== 6'b110000) begin
            n_fail++;
            $display("FAIL reset_passthrough: ctl=%b expected 110000",
                     {pc_write, IF_ID_write, ID_EX_bubble, IF_ID_flush, ID_EX_flush, EX_MEM_flush});
        end
        step();
        do_reset();
    endtask

    task automatic test_load_use();
        do_reset();
        ID_EX_MemRead = 1; ID_EX_rt = 5'd2; ID_rs = 5'd2; ID_rt = 5'd3; ID_uses_rt = 1;
        #1;
        n_checks++;
        if ({pc_write, IF_ID_write, ID_EX_bubble} !== 3'b001) begin
            n_fail++;
            $display("FAIL load_use_stall: pcw/ifw/bub=%b expected 001", {pc_write, IF_ID_write, ID_EX_bubble});
        end
        step();
        // The bubble now sits in ID/EX.
        ID_EX_MemRead = 0; ID_EX_rt = 0;
        #1;
        n_checks++;
        if ({pc_write, IF_ID_write, ID_EX_bubble} !== 3'b110 || stall_cnt !== 16'd1 || state !== 2'd0) begin
            n_fail++;
            $display("FAIL load_use_release: ctl=%b stall_cnt=%0d state=%0d expected 110/1/0",
                     {pc_write, IF_ID_write, ID_EX_bubble}, stall_cnt, state);
        end
        // rt match only counts when the IF/ID instruction reads rt.
        ID_EX_MemRead = 1; ID_EX_rt = 5'd3; ID_rs = 5'd2; ID_rt = 5'd3; ID_uses_rt = 0;
        #1;
        n_checks++;
        if (ID_EX_bubble !== 1'b0 || pc_write !== 1'b1) begin
            n_fail++;
            $display("FAIL load_use_no_rt: bub=%b pcw=%b expected 0/1", ID_EX_bubble, pc_write);
        end
        ID_EX_rt = 5'd0; ID_rs = 5'd0;
        #1;
        n_checks++;
        if (ID_EX_bubble !== 1'b0) begin
            n_fail++;
            $display("FAIL load_use_zero_reg: bub=%b expected 0", ID_EX_bubble);
        end
        step();
    endtask

    task automatic test_flush();
        do_reset();
        MEM_IF_pc_src = 1;
        #1;
        n_checks++;
        if ({IF_ID_flush, ID_EX_flush, EX_MEM_flush, pc_write} !== 4'b1111) begin
            n_fail++;
            $display("FAIL flush_pulse: flushes/pcw=%b expected 1111", {IF_ID_flush, ID_EX_flush, EX_MEM_flush, pc_write});
        end
        step();
        MEM_IF_pc_src = 0;
        ID_EX_MemRead = 1; ID_EX_rt = 5'd7; ID_rs = 5'd7;
        #1;
        n_checks++;
        if (state !== 2'd2 || flush_cnt !== 16'd1 || ID_EX_bubble !== 1'b0 || pc_write !== 1'b1 ||
            IF_ID_flush !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_state: state=%0d flush_cnt=%0d bub=%b pcw=%b iff=%b expected 2/1/0/1/0",
                     state, flush_cnt, ID_EX_bubble, pc_write, IF_ID_flush);
        end
        step();
        clear_inputs();
        #1;
        n_checks++;
        if (state !== 2'd0 || stall_cnt !== 16'd0 || flush_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL flush_exit: state=%0d stall_cnt=%0d flush_cnt=%0d expected 0/0/1", state, stall_cnt, flush_cnt);
        end
    endtask

    task automatic test_freeze();
        do_reset();
        ID_EX_MemRead = 1; ID_EX_rt = 5'd9; ID_rs = 5'd9;
        mem_busy = 1; MEM_IF_pc_src = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if ({pc_write, IF_ID_write, ID_EX_bubble, IF_ID_flush, ID_EX_flush, EX_MEM_flush} !== 6'b000000) begin
                n_fail++;
                $display("FAIL freeze_cycle%0d: ctl=%b expected 000000", i,
                         {pc_write, IF_ID_write, ID_EX_bubble, IF_ID_flush, ID_EX_flush, EX_MEM_flush});
            end
            step();
        end
        mem_busy = 0; MEM_IF_pc_src = 0;
        #1;
        n_checks++;
        if (state !== 2'd1 || freeze_cnt !== 16'd3 || s_freeze_cnt !== 2'd3 ||
            {pc_write, IF_ID_write, ID_EX_bubble} !== 3'b001) begin
            n_fail++;
            $display("FAIL freeze_release: state=%0d freeze_cnt=%0d ctl=%b expected 1/3/001",
                     state, freeze_cnt, {pc_write, IF_ID_write, ID_EX_bubble});
        end
        step();
        ID_EX_MemRead = 0; ID_EX_rt = 0;
        #1;
        n_checks++;
        if (state !== 2'd0 || stall_cnt !== 16'd1 || {pc_write, IF_ID_write, ID_EX_bubble} !== 3'b110) begin
            n_fail++;
            $display("FAIL freeze_after: state=%0d stall_cnt=%0d ctl=%b expected 0/1/110",
                     state, stall_cnt, {pc_write, IF_ID_write, ID_EX_bubble});
        end
    endtask

    task automatic test_forward();
        clear_inputs();
        EX_MEM_dest = 5'd5; MEM_WB_dest = 5'd5; EX_MEM_RegWrite = 1; MEM_WB_RegWrite = 1;
        ID_EX_rs = 5'd5; ID_EX_rt = 5'd6;
        #1;
        n_checks++;
        if (forward_a !== 2'b10 || forward_b !== 2'b00) begin
            n_fail++;
            $display("FAIL fwd_ex_mem: a=%b b=%b expected 10/00", forward_a, forward_b);
        end
        EX_MEM_dest = 5'd0; ID_EX_rt = 5'd5;
        #1;
        n_checks++;
        if (forward_a !== 2'b01 || forward_b !== 2'b01) begin
            n_fail++;
            $display("FAIL fwd_mem_wb: a=%b b=%b expected 01/01", forward_a, forward_b);
        end
        MEM_WB_dest = 5'd0; ID_EX_rs = 5'd0; ID_EX_rt = 5'd0; EX_MEM_dest = 5'd0;
        #1;
        n_checks++;
        if (forward_a !== 2'b00 || forward_b !== 2'b00) begin
            n_fail++;
            $display("FAIL fwd_zero_reg: a=%b b=%b expected 00/00", forward_a, forward_b);
        end
        step();
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            MEM_IF_pc_src = 1;
            step();
            MEM_IF_pc_src = 0;
            step();
        end
        n_checks++;
        if (s_flush_cnt !== 2'd3 || flush_cnt !== 16'd5) begin
            n_fail++;
            $display("FAIL flush_saturate: small=%0d wide=%0d expected 3/5", s_flush_cnt, flush_cnt);
        end
    endtask

    task automatic test_random();
        int m_state;
        int m_stall, m_flush, m_freeze;
        logic [5:0] exp_ctl;
        logic [1:0] exp_a, exp_b;
        int nxt;
        logic lu;
        do_reset();
        m_state = 0; m_stall = 0; m_flush = 0; m_freeze = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            ID_rs = 5'($urandom_range(0, 3));
            ID_rt = 5'($urandom_range(0, 3));
            ID_uses_rt = 1'($urandom_range(0, 1));
            ID_EX_rs = 5'($urandom_range(0, 3));
            ID_EX_rt = 5'($urandom_range(0, 3));
            ID_EX_MemRead = ($urandom_range(0, 2) == 0);
            EX_MEM_RegWrite = 1'($urandom_range(0, 1));
            EX_MEM_dest = 5'($urandom_range(0, 3));
            MEM_WB_RegWrite = 1'($urandom_range(0, 1));
            MEM_WB_dest = 5'($urandom_range(0, 3));
            mem_busy = ($urandom_range(0, 3) == 0);
            MEM_IF_pc_src = ($urandom_range(0, 4) == 0);
            #1;
            lu = ID_EX_MemRead && ID_EX_rt != 0 && (ID_EX_rt == ID_rs || (ID_uses_rt && ID_EX_rt == ID_rt));
            if (mem_busy) begin
                exp_ctl = 6'b000000; nxt = 1; m_freeze++;
            end else if (MEM_IF_pc_src) begin
                exp_ctl = 6'b110111; nxt = 2; m_flush++;
            end else if (m_state != 2 && lu) begin
                exp_ctl = 6'b001000; nxt = 0; m_stall++;
            end else begin
                exp_ctl = 6'b110000; nxt = 0;
            end
            exp_a = fwd_model(ID_EX_rs);
            exp_b = fwd_model(ID_EX_rt);
            n_checks++;
            if ({pc_write, IF_ID_write, ID_EX_bubble, IF_ID_flush, ID_EX_flush, EX_MEM_flush} !== exp_ctl ||
                state !== 2'(m_state)) begin
                n_fail++;
                $display("FAIL rand_ctl cyc=%0d: ctl=%b state=%0d expected %b/%0d", cyc,
                         {pc_write, IF_ID_write, ID_EX_bubble, IF_ID_flush, ID_EX_flush, EX_MEM_flush},
                         state, exp_ctl, m_state);
            end
            n_checks++;
            if (forward_a !== exp_a || forward_b !== exp_b) begin
                n_fail++;
                $display("FAIL rand_fwd cyc=%0d: a=%b b=%b expected %b/%b", cyc, forward_a, forward_b, exp_a, exp_b);
            end
            step();
            m_state = nxt;
            n_checks++;
            if (stall_cnt !== 16'(m_stall) || flush_cnt !== 16'(m_flush) || freeze_cnt !== 16'(m_freeze) ||
                s_stall_cnt !== 2'((m_stall > 3) ? 3 : m_stall) ||
                s_flush_cnt !== 2'((m_flush > 3) ? 3 : m_flush) ||
                s_freeze_cnt !== 2'((m_freeze > 3) ? 3 : m_freeze)) begin
                n_fail++;
                $display("FAIL rand_cnt cyc=%0d: got %0d/%0d/%0d small %0d/%0d/%0d expected %0d/%0d/%0d", cyc,
                         stall_cnt, flush_cnt, freeze_cnt, s_stall_cnt, s_flush_cnt, s_freeze_cnt,
                         m_stall, m_flush, m_freeze);
            end
        end
    endtask

    task automatic test_reset_mid_freeze();
        do_reset();
        MEM_IF_pc_src = 1;
        step();
        MEM_IF_pc_src = 0;
        mem_busy = 1;
        EX_MEM_RegWrite = 1; EX_MEM_dest = 5'd8; ID_EX_rs = 5'd8;
        step();
        step();
        n_checks++;
        if (state !== 2'd1 || freeze_cnt !== 16'd2 || flush_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL pre_reset_freeze: state=%0d freeze_cnt=%0d flush_cnt=%0d expected 1/2/1",
                     state, freeze_cnt, flush_cnt);
        end
        #3;
        RST_N = 1'b0;
        #1;
        n_checks++;
        if (state !== 2'd0 || stall_cnt !== 0 || flush_cnt !== 0 || freeze_cnt !== 0 ||
            s_state !== 2'd0 || s_flush_cnt !== 0 || s_freeze_cnt !== 0) begin
            n_fail++;
            $display("FAIL async_reset: state=%0d cnts=%0d/%0d/%0d expected all 0", state, stall_cnt, flush_cnt, freeze_cnt);
        end
        n_checks++;
        if ({pc_write, IF_ID_write, ID_EX_bubble, IF_ID_flush, ID_EX_flush, EX_MEM_flush} !== 6'b110000 ||
            forward_a !== 2'b10) begin
            n_fail++;
            $display("FAIL reset_outputs: ctl=%b fwd_a=%b expected 110000/10",
                     {pc_write, IF_ID_write, ID_EX_bubble, IF_ID_flush, ID_EX_flush, EX_MEM_flush}, forward_a);
        end
        mem_busy = 0;
        step();
        RST_N = 1'b1;
        #1;
        n_checks++;
        if (state !== 2'd0 || {IF_ID_flush, ID_EX_flush, EX_MEM_flush} !== 3'b000 || freeze_cnt !== 0) begin
            n_fail++;
            $display("FAIL reset_exit: state=%0d flushes=%b freeze_cnt=%0d expected 0/000/0",
                     state, {IF_ID_flush, ID_EX_flush, EX_MEM_flush}, freeze_cnt);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        clear_inputs();
        RST_N = 1'b1;
        test_reset();
        test_load_use();
        test_flush();
        test_freeze();
        test_forward();
        test_saturation();
        test_random();
        test_reset_mid_freeze();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
